// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: frames a byte for the external TX shift register,
// loads it, then issues one right-shift per bit period and reports start/busy/done.
module uart_tx_sequencer #(
  parameter int WORD_LENGTH  = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  localparam int FRAME_W     = 1 + WORD_LENGTH + PARITY_EN + STOP_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [WORD_LENGTH-1:0] data_in_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   tx_o,
  output logic                   sr_load_o,
  output logic                   sr_shift_o,
  output logic                   sr_right_o,
  output logic                   sr_serial_in_o,
  output logic                   sr_sync_reset_o,
  output logic [FRAME_W-1:0]     sr_frame_o,
  input  logic                   sr_lsb_i
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(FRAME_W);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [BIT_W-1:0]   bit_q, bit_d;

  function automatic logic parity_bit(input logic [WORD_LENGTH-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  assign sr_right_o     = 1'b1;
  assign sr_serial_in_o = 1'b1;

  // Start bit in the LSB; stop bits fill everything above data/parity.
  always_comb begin
    sr_frame_o                  = '1;
    sr_frame_o[0]               = 1'b0;
    sr_frame_o[WORD_LENGTH:1]   = data_in_i;
    if (PARITY_EN != 0) begin
      sr_frame_o[WORD_LENGTH+1] = parity_bit(data_in_i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    baud_d          = baud_q;
    bit_d           = bit_q;
    busy_o          = 1'b0;
    done_o          = 1'b0;
    tx_o            = 1'b1;
    sr_load_o       = 1'b0;
    sr_shift_o      = 1'b0;
    sr_sync_reset_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Gate with reset so no load strobe leaks out while reset is held.
        if (start_i && reset) begin
          sr_load_o = 1'b1;
          baud_d    = '0;
          bit_d     = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        busy_o = 1'b1;
        tx_o   = sr_lsb_i;
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            sr_sync_reset_o = 1'b1;
            state_d         = DONE;
          end else begin
            sr_shift_o = 1'b1;
            bit_d      = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
